// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and the round-robin pick used by the adder arbiter.
// The tag carries the requester id alongside each operation in the adder pipeline.
package adder_rr_arbiter_pkg;

   localparam int NREQ_MAX  = 8;
   localparam int ID_W      = 3;
   localparam int ADDER_LAT = 2;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   // One-hot grant to the first set bit of elig, scanning ptr, ptr+1, ... modulo n.
   function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] elig,
                                                   input logic [ID_W-1:0]     ptr,
                                                   input int                  n);
      logic [NREQ_MAX-1:0] grant;
      logic                found;
      logic [ID_W-1:0]     idx;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ_MAX; k++) begin
         if (k < n) begin
            idx = ID_W'((int'(ptr) + k) % n);
            if (!found && elig[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Requester-facing bus of the shared adder: one request and one response channel per requester.
// Valid/ready: a transfer happens on a rising edge where valid & ready; valid never waits on ready.
interface adder_rr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_cin;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [NREQ*WIDTH-1:0] rsp_sum;
   logic [NREQ-1:0]       rsp_cout;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/adder_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from a registered start pointer.
// The pointer moves to one past the winner whenever a grant is given.
module rr_arbiter
   import adder_rr_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         elig,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] ptr
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]       ptr_d, ptr_q;
   logic [NREQ_MAX-1:0] elig_w, pick_w;
   logic                unused_pick;

   always_comb begin
      elig_w             = '0;
      elig_w[NREQ-1:0]   = elig;
      pick_w             = rr_pick(elig_w, ID_W'(ptr_q), NREQ);
      grant              = rst ? '0 : pick_w[NREQ-1:0];
      ptr_d              = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
   end

   assign unused_pick = ^pick_w;

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
endmodule

// File: rtl/pipeline_carry_skip_adder.sv
// Two-stage adder: low half in stage 1, high half in stage 2, each half a 4-bit-block carry-skip chain.
// WIDTH must be even; the result appears two rising edges after the operands.
module pipeline_carry_skip_adder #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int H = WIDTH / 2;

   function automatic logic [H:0] csk(input logic [H-1:0] x, input logic [H-1:0] y, input logic c0);
      logic [H-1:0] s;
      logic         c, cblk, pblk;
      c    = c0;
      cblk = c0;
      pblk = 1'b1;
      for (int i = 0; i < H; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
         pblk = pblk & (x[i] ^ y[i]);
         // A fully propagating block forwards its incoming carry directly.
         if ((i % 4) == 3 || i == H - 1) begin
            if (pblk) c = cblk;
            cblk = c;
            pblk = 1'b1;
         end
      end
      return {c, s};
   endfunction

   logic [H-1:0] s_lo_d, s_lo_q, a_hi_q, b_hi_q, s_hi_d;
   logic         c_lo_d, c_lo_q, c_hi_d;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;

   always_comb begin
      {c_lo_d, s_lo_d} = csk(a[H-1:0], b[H-1:0], cin);
      {c_hi_d, s_hi_d} = csk(a_hi_q, b_hi_q, c_lo_q);
      sum_d  = {s_hi_d, s_lo_q};
      cout_d = c_hi_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_lo_q <= '0;
         c_lo_q <= 1'b0;
         a_hi_q <= '0;
         b_hi_q <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         s_lo_q <= s_lo_d;
         c_lo_q <= c_lo_d;
         a_hi_q <= a[WIDTH-1:H];
         b_hi_q <= b[WIDTH-1:H];
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one pipelined adder among NREQ requesters, with one outstanding operation each.
// A tag pipeline follows every issued operation so its result lands in the owner's buffer.
module adder_rr_arbiter
   import adder_rr_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   parameter int LAT   = ADDER_LAT
) (
   input  logic                    clk,
   input  logic                    rst,
   adder_rr_arbiter_if.slave       bus,
   output logic [$clog2(NREQ)-1:0] dbg_ptr
);
   logic [NREQ-1:0]  elig, grant, hs;
   logic [ID_W-1:0]  g_idx;
   logic             issue;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout;

   tag_t             tag_d [LAT];
   tag_t             tag_q [LAT];
   logic [NREQ-1:0]  out_d, out_q;
   logic [NREQ-1:0]  rsp_valid_d, rsp_valid_q;
   logic [NREQ-1:0]  rsp_cout_d, rsp_cout_q;
   logic [WIDTH-1:0] rsp_sum_d [NREQ];
   logic [WIDTH-1:0] rsp_sum_q [NREQ];

   assign elig = bus.req_valid & ~out_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .elig  (elig),
      .grant (grant),
      .ptr   (dbg_ptr)
   );

   assign bus.req_ready = grant;

   // Idle cycles feed zeros so the adder pipeline carries no stale operands.
   always_comb begin
      issue   = |grant;
      g_idx   = '0;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_idx   = ID_W'(i);
            add_a   = bus.req_a[i*WIDTH +: WIDTH];
            add_b   = bus.req_b[i*WIDTH +: WIDTH];
            add_cin = bus.req_cin[i];
         end
      end
   end

   pipeline_carry_skip_adder #(.WIDTH(WIDTH)) u_add (
      .clk  (clk),
      .rst  (rst),
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      tag_d[0].valid = issue;
      tag_d[0].id    = g_idx;
      for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
   end

   // A completion never collides with a handshake on the same requester: out_j is still set.
   always_comb begin
      hs          = rsp_valid_q & bus.rsp_ready;
      out_d       = (out_q & ~hs) | grant;
      rsp_valid_d = rsp_valid_q & ~hs;
      rsp_cout_d  = rsp_cout_q;
      rsp_sum_d   = rsp_sum_q;
      for (int i = 0; i < NREQ; i++) begin
         if (tag_q[LAT-1].valid && tag_q[LAT-1].id == ID_W'(i)) begin
            rsp_valid_d[i] = 1'b1;
            rsp_sum_d[i]   = add_sum;
            rsp_cout_d[i]  = add_cout;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         rsp_valid_q <= '0;
         rsp_cout_q  <= '0;
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
         for (int i = 0; i < NREQ; i++) rsp_sum_q[i] <= '0;
      end else begin
         out_q       <= out_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_cout_q  <= rsp_cout_d;
         tag_q       <= tag_d;
         rsp_sum_q   <= rsp_sum_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = |out_q;

   for (genvar i = 0; i < NREQ; i++) begin : g_rsp
      assign bus.rsp_sum[i*WIDTH +: WIDTH] = rsp_sum_q[i];
   end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: directed and random phases checked every cycle against a
// transaction-level model (grant rotation, fixed-latency results, per-requester buffers).
module tb_adder_rr_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 64;
   localparam int LAT   = 2;
   localparam int W     = WIDTH + 1;

   logic                    clk;
   logic                    rst;
   logic [$clog2(NREQ)-1:0] dbg_ptr;

   adder_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .dbg_ptr (dbg_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: outstanding flags, buffered results, countdown to completion, search pointer.
   logic [NREQ-1:0] m_out;
   logic [NREQ-1:0] m_rsp_v;
   logic [W-1:0]    m_res [NREQ];
   int              m_cnt [NREQ];
   int              m_ptr;
   logic [W-1:0]    exp_q [$];
   int              obs_grants [NREQ];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out   = '0;
      m_rsp_v = '0;
      m_ptr   = 0;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) begin
         m_res[i] = '0;
         m_cnt[i] = 0;
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] elig);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (elig[idx]) return idx;
      end
      return -1;
   endfunction

   // Sample at the falling edge, compare, advance the model across the next rising edge.
   task automatic cycle();
      logic [NREQ-1:0] elig, exp_rdy, hs;
      logic [W-1:0]    res;
      int              g;
      @(negedge clk);
      elig    = bus.req_valid & ~m_out;
      g       = rst ? -1 : model_pick(elig);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", W'(bus.req_ready), W'(exp_rdy));
      check("busy", W'(bus.busy), W'(|m_out));
      check("ptr", W'(dbg_ptr), W'(m_ptr));
      for (int i = 0; i < NREQ; i++) begin
         obs_grants[i] += int'(bus.req_ready[i]);
         check($sformatf("rsp_valid[%0d]", i), W'(bus.rsp_valid[i]), W'(m_rsp_v[i]));
         check($sformatf("rsp_result[%0d]", i), {bus.rsp_cout[i], bus.rsp_sum[i*WIDTH +: WIDTH]}, m_res[i]);
      end
      if (rst) begin
         model_reset();
      end else begin
         hs = m_rsp_v & bus.rsp_ready;
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
               m_rsp_v[i] = 1'b0;
               m_out[i]   = 1'b0;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (m_cnt[i] > 0) begin
               m_cnt[i]--;
               if (m_cnt[i] == 0) begin
                  m_res[i]   = exp_q.pop_front();
                  m_rsp_v[i] = 1'b1;
               end
            end
         end
         if (g >= 0) begin
            res = W'(bus.req_a[g*WIDTH +: WIDTH]) + W'(bus.req_b[g*WIDTH +: WIDTH]) + W'(bus.req_cin[g]);
            exp_q.push_back(res);
            m_out[g] = 1'b1;
            m_cnt[g] = LAT;
            m_ptr    = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic random_ops();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*WIDTH +: WIDTH] = {$urandom, $urandom};
         bus.req_b[i*WIDTH +: WIDTH] = {$urandom, $urandom};
         bus.req_cin[i]              = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_cin[i]              = cin;
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      for (int n = 0; n < 6; n++) cycle();
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < NREQ; i++) obs_grants[i] = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      random_ops();
      cycle();
      cycle();
      bus.req_valid = '1;
      cycle();
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      cycle();

      // Single request with a full-width carry out.
      set_ops(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      bus.req_valid = 4'b0001;
      cycle();
      bus.req_valid = '0;
      for (int n = 0; n < 5; n++) cycle();

      // Carry rippling through several 4-bit blocks.
      set_ops(1, 64'h0000_0000_00FF_FFFF, 64'd0, 1'b1);
      bus.req_valid = 4'b0010;
      cycle();
      bus.req_valid = '0;
      for (int n = 0; n < 5; n++) cycle();

      // All requesters valid, responses always accepted.
      bus.req_valid = '1;
      for (int n = 0; n < 40; n++) begin
         random_ops();
         cycle();
      end
      drain();

      // Back-pressure on requester 2 only.
      for (int i = 0; i < NREQ; i++) obs_grants[i] = 0;
      bus.req_valid = '1;
      bus.rsp_ready = 4'b1011;
      for (int n = 0; n < 20; n++) begin
         random_ops();
         cycle();
      end
      check("bp_grants_req2", W'(obs_grants[2]), W'(1));
      check("bp_req0_rotates", W'(obs_grants[0] >= 4), W'(1));
      check("bp_req3_rotates", W'(obs_grants[3] >= 4), W'(1));
      drain();

      // Requester 0 alone: its handshake cycle coincides with req_valid[0].
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 4'b0001;
      for (int n = 0; n < 12; n++) begin
         random_ops();
         cycle();
      end
      drain();

      // Random valid and ready patterns.
      for (int n = 0; n < 150; n++) begin
         random_ops();
         bus.req_valid = 4'($urandom_range(0, 15));
         bus.rsp_ready = 4'($urandom_range(0, 15));
         cycle();
      end
      drain();

      // Reset with requesters 1 and 3 in flight.
      bus.req_valid = 4'b1010;
      random_ops();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst           = 1'b0;
      bus.req_valid = '1;
      for (int n = 0; n < 12; n++) begin
         random_ops();
         cycle();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
